// File: rtl/vga_sync_decoder.sv
// Recovers active-pixel coordinates and a timing-lock indication from a VGA
// sync/blank stream; colour is re-registered so it lines up with x/y/pix_valid.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank_b,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [7:0] pix_r,
    output logic [7:0] pix_g,
    output logic [7:0] pix_b,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_cnt
);
    localparam int          GW     = ($clog2(LOCK_FRAMES + 1) > 0) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam logic [10:0] C_HTOT = 11'(H_TOTAL);
    localparam logic [9:0]  C_VTOT = 10'(V_TOTAL);
    localparam logic [9:0]  C_XMAX = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  C_YMAX = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
    state_t r_state, w_state_nxt;

    logic          r_hs1, r_hs2, r_vs1, r_vs2, r_bl1, r_bl2;
    logic [7:0]    r_r1, r_g1, r_b1, r_pix_r, r_pix_g, r_pix_b;
    logic [9:0]    r_hcnt, r_vcnt, r_x, r_y;
    logic          r_seen_h, r_line_bad, r_frame_start;
    logic [GW-1:0] r_good_cnt;
    logic [7:0]    r_err_cnt;

    logic          w_hfall, w_vfall, w_brise, w_bfall;
    logic          w_line_fail, w_frame_ok, w_frame_good;
    logic          w_locked, w_err_inc;
    logic [GW:0]   w_good_inc;

    // Sync stages idle high and blank idles low, so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs1   <= 1'b1;
            r_hs2   <= 1'b1;
            r_vs1   <= 1'b1;
            r_vs2   <= 1'b1;
            r_bl1   <= 1'b0;
            r_bl2   <= 1'b0;
            r_r1    <= '0;
            r_g1    <= '0;
            r_b1    <= '0;
            r_pix_r <= '0;
            r_pix_g <= '0;
            r_pix_b <= '0;
        end else begin
            r_hs1   <= hsync;
            r_hs2   <= r_hs1;
            r_vs1   <= vsync;
            r_vs2   <= r_vs1;
            r_bl1   <= blank_b;
            r_bl2   <= r_bl1;
            r_r1    <= r;
            r_g1    <= g;
            r_b1    <= b;
            r_pix_r <= r_r1;
            r_pix_g <= r_g1;
            r_pix_b <= r_b1;
        end
    end

    assign w_hfall = r_hs2 & ~r_hs1;
    assign w_vfall = r_vs2 & ~r_vs1;
    assign w_brise = ~r_bl2 & r_bl1;
    assign w_bfall = r_bl2 & ~r_bl1;

    assign w_line_fail  = w_hfall & r_seen_h & (({1'b0, r_hcnt} + 11'd1) != C_HTOT);
    assign w_frame_ok   = (r_vcnt == C_VTOT);
    assign w_frame_good = w_frame_ok & ~r_line_bad & ~w_line_fail;
    assign w_good_inc   = {1'b0, r_good_cnt} + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcnt     <= '0;
            r_vcnt     <= '0;
            r_seen_h   <= 1'b0;
            r_line_bad <= 1'b0;
        end else begin
            if (w_hfall) begin
                r_hcnt   <= '0;
                r_seen_h <= 1'b1;
            end else if (r_hcnt != '1) begin
                r_hcnt <= r_hcnt + 10'd1;
            end

            // The line ending on the same cycle as vsync fall belongs to the old frame.
            if (w_vfall) begin
                r_vcnt     <= w_hfall ? 10'd1 : 10'd0;
                r_line_bad <= 1'b0;
            end else begin
                if (w_hfall && r_vcnt != '1) begin
                    r_vcnt <= r_vcnt + 10'd1;
                end
                if (w_line_fail) begin
                    r_line_bad <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (w_brise) begin
                r_x <= '0;
            end else if (r_bl1 && r_x != C_XMAX) begin
                r_x <= r_x + 10'd1;
            end

            if (w_vfall) begin
                r_y <= '0;
            end else if (w_bfall && r_y != C_YMAX) begin
                r_y <= r_y + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEARCH: begin
                if (w_vfall) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (w_vfall && w_frame_good && int'(w_good_inc) == LOCK_FRAMES) begin
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (w_line_fail || (w_vfall && !w_frame_ok)) begin
                    w_state_nxt = SEARCH;
                end
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        w_locked  = (r_state == LOCKED);
        w_err_inc = w_locked & (w_line_fail | (w_vfall & ~w_frame_ok));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_good_cnt    <= '0;
            r_err_cnt     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_vfall;
            if (w_vfall) begin
                if (r_state == SEARCH) begin
                    r_good_cnt <= '0;
                end else if (r_state == CHECK) begin
                    r_good_cnt <= w_frame_good ? w_good_inc[GW-1:0] : '0;
                end
            end
            if (w_err_inc && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign pix_r       = r_pix_r;
    assign pix_g       = r_pix_g;
    assign pix_b       = r_pix_b;
    assign pix_valid   = r_bl2 & w_locked;
    assign frame_start = r_frame_start;
    assign locked      = w_locked;
    assign err_cnt     = r_err_cnt;
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_TOTAL, 800, pixel clocks per line.
REQ-002 SHALL have parameter H_ACTIVE, 640, active pixels per line.
REQ-003 SHALL have parameter V_TOTAL, 525, lines per frame.
REQ-004 SHALL have parameter V_ACTIVE, 480, active lines per frame.
REQ-005 SHALL have parameter LOCK_FRAMES, 2, consecutive good frames needed for lock.
REQ-006 SHALL have one clock and an asynchronous, active-low reset; ports are as follows (name, direction, width, meaning).
REQ-007 clk  in  1  pixel clock, 25.175 MHz; all logic on rising edge.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 hsync, vsync  in  1 each  active-low sync from the VGA source.
REQ-010 blank_b  in  1  high during active video.
REQ-011 r, g, b  in  8 each  pixel colour.
REQ-012 x, y  out  10 each  recovered active-pixel coordinate.
REQ-013 pix_r, pix_g, pix_b  out  8 each  registered pixel colour.
REQ-014 pix_valid  out  1  pixel outputs valid this cycle.
REQ-015 frame_start  out  1  one-cycle pulse on each detected vsync falling edge.
REQ-016 locked  out  1  timing matches parameters.
REQ-017 err_cnt  out  8  timing errors seen while locked; saturates at 255.

Function
REQ-018 SHALL register all inputs once (stage 1); edge detection SHALL compare stage 1 with a stage-2 copy.
REQ-019 hsync fall SHALL be stage-2 = 1 with stage-1 = 0; vsync fall and blank_b rise/fall SHALL use the same rule.
REQ-020 hcnt (10 bit) SHALL reset to 0 on hsync fall, otherwise increment, saturating at 1023.
REQ-021 On each hsync fall after the first since reset, line length = hcnt+1; line_ok SHALL be (length == H_TOTAL).
REQ-022 vcnt (10 bit) SHALL increment on each hsync fall, saturating at 1023.
REQ-023 On vsync fall, frame_ok SHALL be (vcnt == V_TOTAL); vcnt then SHALL load 1 if hsync also falls that cycle, else 0.
REQ-024 A frame is good when frame_ok holds and no line_ok failure occurred since the previous vsync fall.
REQ-025 x SHALL load 0 on blank_b rise and increment each cycle blank_b (stage 1) is high, saturating at H_ACTIVE-1.
REQ-026 y SHALL reset to 0 on vsync fall and increment on each blank_b fall, saturating at V_ACTIVE-1.
REQ-027 pix_r/g/b SHALL be input r/g/b delayed 2 cycles; x, y, and pix_valid SHALL be aligned to the same pixel.
REQ-028 pix_valid SHALL equal delayed blank_b AND locked.
REQ-029 Lock FSM states: SEARCH, CHECK, LOCKED.
REQ-030 SEARCH: on vsync fall, go to CHECK and clear good_cnt.
REQ-031 CHECK, on vsync fall with good frame: increment good_cnt; go to LOCKED when good_cnt reaches LOCK_FRAMES.
REQ-032 CHECK, on vsync fall with bad frame: clear good_cnt and stay in CHECK.
REQ-033 CHECK, any line_ok failure: mark the frame bad, stay in CHECK.
REQ-034 LOCKED, any line_ok failure or bad frame_ok: go to SEARCH and increment err_cnt by 1 (maximum 1 per cycle).
REQ-035 locked SHALL be 1 only in LOCKED and SHALL deassert the cycle after the failing edge is detected.
REQ-036 frame_start SHALL pulse in every state, the cycle after the vsync fall is detected.

Reset
REQ-037 While rst is low, all outputs, counters, pipeline stages, and good_cnt SHALL be 0; the FSM SHALL be in SEARCH.
REQ-038 Edge-detect stages SHALL reset to 1 for hsync and vsync, and to 0 for blank_b, so no edge is seen at release.
REQ-039 Reset asserted mid-frame SHALL abort lock immediately; relock SHALL require LOCK_FRAMES full good frames after the first vsync fall.

Verification
REQ-040 Nominal 640x480 stream from reset -> locked rises 1 cycle after the 3rd vsync fall; err_cnt = 0.
REQ-041 Active line in locked state -> pix_valid high for exactly 640 cycles; x runs 0..639; y runs 0..479 across the frame.
REQ-042 Pixel r = 8'hA5 at input cycle N in an active region -> pix_r = 8'hA5 at cycle N+2 with the matching x.
REQ-043 One 799-clock line while locked -> locked drops, err_cnt = 1, FSM in SEARCH; relock after 2 further good frames.
REQ-044 Frame of 524 lines during CHECK -> good_cnt cleared, locked stays 0, err_cnt unchanged.
REQ-045 rst low for 3 cycles mid-active-line while locked -> all outputs 0 immediately; normal relock follows.
